ama_riscv_alu_arbiter: RTL and testbench

Shares a single `ama_riscv_alu` instance between two requesters (e.g. main pipeline and a multi-cycle helper unit) using round-robin arbitration with valid/ready handshakes. Each requester has its own one-entry registered response buffer, so the ALU result is returned exactly one cycle after acceptance. Per-requester saturating grant counters support performance debug. The ALU is instantiated inside the block; its op encoding (ADD 0000, SUB 1000, SLL 0001, SRL 0101, SRA 1101, SLT 0010, SLTU 0011, XOR 0100, OR 0110, AND 0111, PASS_B 1111, others → 0) applies unchanged.

---
 rtl/ama_riscv_alu_arbiter.sv | 162 ++++++++++++++++
 tb/tb_ama_riscv_alu_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ama_riscv_alu_arbiter.sv
// Round-robin arbiter sharing one ama_riscv_alu between two requesters, with
// a one-entry registered response buffer and saturating grant counter per requester.

module ama_riscv_alu #(
   parameter int DATA_W = 32
) (
   input  logic [3:0]        op_sel,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   output logic [DATA_W-1:0] out_s
);
   localparam int SH_W = $clog2(DATA_W);

   localparam logic [3:0] OP_ADD    = 4'b0000;
   localparam logic [3:0] OP_SUB    = 4'b1000;
   localparam logic [3:0] OP_SLL    = 4'b0001;
   localparam logic [3:0] OP_SRL    = 4'b0101;
   localparam logic [3:0] OP_SRA    = 4'b1101;
   localparam logic [3:0] OP_SLT    = 4'b0010;
   localparam logic [3:0] OP_SLTU   = 4'b0011;
   localparam logic [3:0] OP_XOR    = 4'b0100;
   localparam logic [3:0] OP_OR     = 4'b0110;
   localparam logic [3:0] OP_AND    = 4'b0111;
   localparam logic [3:0] OP_PASS_B = 4'b1111;

   logic signed [DATA_W-1:0] a_s;
   logic signed [DATA_W-1:0] b_s;
   logic        [SH_W-1:0]   shamt;

   assign a_s   = $signed(in_a);
   assign b_s   = $signed(in_b);
   assign shamt = in_b[SH_W-1:0];

   always_comb begin
      out_s = '0;
      case (op_sel)
         OP_ADD:    out_s = in_a + in_b;
         OP_SUB:    out_s = in_a - in_b;
         OP_SLL:    out_s = in_a << shamt;
         OP_SRL:    out_s = in_a >> shamt;
         OP_SRA:    out_s = a_s >>> shamt;
         OP_SLT:    out_s = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
         OP_SLTU:   out_s = {{(DATA_W-1){1'b0}}, (in_a < in_b)};
         OP_XOR:    out_s = in_a ^ in_b;
         OP_OR:     out_s = in_a | in_b;
         OP_AND:    out_s = in_a & in_b;
         OP_PASS_B: out_s = in_b;
         default:   out_s = '0;
      endcase
   end
endmodule

module ama_riscv_alu_arbiter #(
   parameter int RR_INIT = 0,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op_sel,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op_sel,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [31:0]      rsp0_data,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [31:0]      rsp1_data,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] gnt_cnt0,
   output logic [CNT_W-1:0] gnt_cnt1
);
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic        rr_ptr;
   logic        elig0;
   logic        elig1;
   logic        gnt0;
   logic        gnt1;
   logic [3:0]  alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_out;

   // Eligible when the response buffer is empty or being drained this cycle
   assign elig0 = req0_valid & (~rsp0_valid | rsp0_ready);
   assign elig1 = req1_valid & (~rsp1_valid | rsp1_ready);
   assign gnt0  = elig0 & (~elig1 | ~rr_ptr);
   assign gnt1  = elig1 & (~elig0 |  rr_ptr);

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   always_comb begin
      alu_op = 4'b0000;
      alu_a  = '0;
      alu_b  = '0;
      if (gnt0) begin
         alu_op = req0_op_sel;
         alu_a  = req0_a;
         alu_b  = req0_b;
      end else if (gnt1) begin
         alu_op = req1_op_sel;
         alu_a  = req1_a;
         alu_b  = req1_b;
      end
   end

   ama_riscv_alu #(.DATA_W(32)) u_alu (
      .op_sel (alu_op),
      .in_a   (alu_a),
      .in_b   (alu_b),
      .out_s  (alu_out)
   );

   // ---- response / arbitration register stage ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr     <= 1'(RR_INIT);
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp0_data  <= '0;
         rsp1_data  <= '0;
         gnt_cnt0   <= '0;
         gnt_cnt1   <= '0;
      end else begin
         if (gnt0)      rr_ptr <= 1'b1;
         else if (gnt1) rr_ptr <= 1'b0;

         if (gnt0) begin
            rsp0_data  <= alu_out;
            rsp0_valid <= 1'b1;
         end else if (rsp0_ready) begin
            rsp0_valid <= 1'b0;
         end

         if (gnt1) begin
            rsp1_data  <= alu_out;
            rsp1_valid <= 1'b1;
         end else if (rsp1_ready) begin
            rsp1_valid <= 1'b0;
         end

         // Clear takes precedence over a same-cycle grant
         if (cnt_clr) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
         end else begin
            if (gnt0) gnt_cnt0 <= sat_inc(gnt_cnt0);
            if (gnt1) gnt_cnt1 <= sat_inc(gnt_cnt1);
         end
      end
   end
endmodule

// File: tb/tb_ama_riscv_alu_arbiter.sv
// Directed bench for ama_riscv_alu_arbiter (RR_INIT=0, CNT_W=2 so saturation is reachable).

module tb_ama_riscv_alu_arbiter;
   localparam int CNT_W = 2;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b0001;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SRA  = 4'b1101;
   localparam logic [3:0] OP_SLT  = 4'b0010;
   localparam logic [3:0] OP_SLTU = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b0111;
   localparam logic [3:0] OP_PASSB = 4'b1111;
   localparam logic [3:0] OP_BAD  = 4'b1010;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req0_valid, req1_valid;
   logic             req0_ready, req1_ready;
   logic [3:0]       req0_op_sel, req1_op_sel;
   logic [31:0]      req0_a, req0_b, req1_a, req1_b;
   logic             rsp0_valid, rsp1_valid;
   logic             rsp0_ready, rsp1_ready;
   logic [31:0]      rsp0_data, rsp1_data;
   logic             cnt_clr;
   logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;

   int tests = 0;
   int fails = 0;

   ama_riscv_alu_arbiter #(.RR_INIT(0), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_op_sel (req0_op_sel),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_op_sel (req1_op_sel),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .rsp0_valid  (rsp0_valid),
      .rsp0_ready  (rsp0_ready),
      .rsp0_data   (rsp0_data),
      .rsp1_valid  (rsp1_valid),
      .rsp1_ready  (rsp1_ready),
      .rsp1_data   (rsp1_data),
      .cnt_clr     (cnt_clr),
      .gnt_cnt0    (gnt_cnt0),
      .gnt_cnt1    (gnt_cnt1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   logic [3:0]  vop [5];
   logic [31:0] va  [5];
   logic [31:0] vb  [5];
   logic [31:0] vr  [5];

   initial begin
      vop[0] = OP_SLL;  va[0] = 32'h1;        vb[0] = 32'd4;     vr[0] = 32'h10;
      vop[1] = OP_SRL;  va[1] = 32'h80000000; vb[1] = 32'd4;     vr[1] = 32'h08000000;
      vop[2] = OP_SLT;  va[2] = 32'hFFFFFFFF; vb[2] = 32'd1;     vr[2] = 32'h1;
      vop[3] = OP_SLTU; va[3] = 32'hFFFFFFFF; vb[3] = 32'd1;     vr[3] = 32'h0;
      vop[4] = OP_AND;  va[4] = 32'hF0F0;     vb[4] = 32'hFF00;  vr[4] = 32'hF000;

      // Reset held with random input activity
      rst_n = 1'b0;
      cnt_clr = 1'b0;
      for (int i = 0; i < 6; i++) begin
         req0_valid  = 1'($urandom);  req1_valid  = 1'($urandom);
         req0_op_sel = 4'($urandom);  req1_op_sel = 4'($urandom);
         req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
         rsp0_ready = 1'($urandom);   rsp1_ready = 1'($urandom);
         cnt_clr = 1'($urandom);
         tick();
      end
      chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
      chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
      chk("rst_rsp0_data", rsp0_data, 32'd0);
      chk("rst_rsp1_data", rsp1_data, 32'd0);
      chk("rst_cnt0", 32'(gnt_cnt0), 32'd0);
      chk("rst_cnt1", 32'(gnt_cnt1), 32'd0);

      // Release; single requester ADD 16+11
      req1_valid = 1'b0; cnt_clr = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      rst_n = 1'b1;
      req0_valid = 1'b1; req0_op_sel = OP_ADD; req0_a = 32'd16; req0_b = 32'd11;
      settle();
      chk("first_req0_ready", 32'(req0_ready), 32'd1);
      chk("first_req1_ready", 32'(req1_ready), 32'd0);
      tick();
      chk("add_rsp0_valid", 32'(rsp0_valid), 32'd1);
      chk("add_rsp0_data", rsp0_data, 32'd27);
      chk("add_cnt0", 32'(gnt_cnt0), 32'd1);

      // Back-to-back ALU vectors from req0 alone
      for (int i = 0; i < 5; i++) begin
         req0_op_sel = vop[i]; req0_a = va[i]; req0_b = vb[i];
         settle();
         chk("b2b_req0_ready", 32'(req0_ready), 32'd1);
         tick();
         chk("b2b_rsp0_data", rsp0_data, vr[i]);
      end
      req0_valid = 1'b0;

      // req1 alone PASS_B; req0 buffer drains, data held
      req1_valid = 1'b1; req1_op_sel = OP_PASSB; req1_a = 32'd5; req1_b = 32'd192;
      settle();
      chk("pass_req1_ready", 32'(req1_ready), 32'd1);
      tick();
      chk("pass_rsp1_data", rsp1_data, 32'd192);
      chk("pass_rsp1_valid", 32'(rsp1_valid), 32'd1);
      chk("drain_rsp0_valid", 32'(rsp0_valid), 32'd0);
      chk("drain_rsp0_hold", rsp0_data, 32'hF000);
      chk("sat_cnt0", 32'(gnt_cnt0), 32'd3);
      req1_valid = 1'b0;
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("clr_cnt0", 32'(gnt_cnt0), 32'd0);
      chk("clr_cnt1", 32'(gnt_cnt1), 32'd0);

      // Contention: grants alternate 0,1,0,1 starting from rr_ptr=0
      req0_valid = 1'b1; req0_op_sel = OP_SUB; req0_a = 32'd17; req0_b = 32'd10;
      req1_valid = 1'b1; req1_op_sel = OP_SRA; req1_a = 32'h23; req1_b = 32'd4;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("rr_req0_ready", 32'(req0_ready), 32'((i % 2) == 0));
         chk("rr_req1_ready", 32'(req1_ready), 32'((i % 2) == 1));
         tick();
      end
      chk("rr_rsp0_data", rsp0_data, 32'd7);
      chk("rr_rsp1_data", rsp1_data, 32'd2);
      chk("rr_cnt0", 32'(gnt_cnt0), 32'd2);
      chk("rr_cnt1", 32'(gnt_cnt1), 32'd2);
      req0_valid = 1'b0; req1_valid = 1'b0;
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;

      // Backpressure on rsp0
      rsp0_ready = 1'b0;
      req0_valid = 1'b1; req0_op_sel = OP_ADD; req0_a = 32'd1; req0_b = 32'd2;
      tick();
      chk("bp_fill_data", rsp0_data, 32'd3);
      req0_a = 32'd10; req0_b = 32'd20;
      req1_valid = 1'b1; req1_op_sel = OP_XOR; req1_a = 32'hF0; req1_b = 32'hFF;
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("bp_req0_ready", 32'(req0_ready), 32'd0);
         chk("bp_req1_ready", 32'(req1_ready), 32'd1);
         tick();
         chk("bp_rsp1_data", rsp1_data, 32'h0F);
         chk("bp_rsp0_hold", rsp0_data, 32'd3);
      end
      rsp0_ready = 1'b1;
      settle();
      chk("bp_release_req0", 32'(req0_ready), 32'd1);
      chk("bp_release_req1", 32'(req1_ready), 32'd0);
      tick();
      chk("bp_regrant_valid", 32'(rsp0_valid), 32'd1);
      chk("bp_regrant_data", rsp0_data, 32'd30);
      chk("bp_cnt0", 32'(gnt_cnt0), 32'd2);
      chk("bp_cnt1", 32'(gnt_cnt1), 32'd2);
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Async reset between edges while rsp0_valid=1
      rst_n = 1'b0;
      settle();
      chk("arst_rsp0_valid", 32'(rsp0_valid), 32'd0);
      chk("arst_rsp0_data", rsp0_data, 32'd0);
      chk("arst_cnt0", 32'(gnt_cnt0), 32'd0);
      tick();
      rst_n = 1'b1;

      // Saturation of req1 counter, clear vs grant, invalid op
      req1_valid = 1'b1; req1_op_sel = OP_OR; req1_a = 32'h1; req1_b = 32'h2;
      for (int i = 0; i < 5; i++) tick();
      chk("sat_cnt1", 32'(gnt_cnt1), 32'd3);
      chk("or_rsp1_data", rsp1_data, 32'd3);
      cnt_clr = 1'b1;
      settle();
      chk("clrgnt_req1_ready", 32'(req1_ready), 32'd1);
      tick();
      chk("clrgnt_cnt1", 32'(gnt_cnt1), 32'd0);
      cnt_clr = 1'b0;
      req1_op_sel = OP_BAD;
      tick();
      chk("post_clr_cnt1", 32'(gnt_cnt1), 32'd1);
      chk("bad_op_data", rsp1_data, 32'd0);
      chk("bad_op_valid", 32'(rsp1_valid), 32'd1);
      req1_valid = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
